player_action_arbiter: RTL
==========================

Name: player_action_arbiter

Overview:
- Per-frame scheduler that shares the single game_logic action-update port among up to 4 players: local debounced buttons and carry switch, plus remote players over the communication link.
- On each frame tick (vsync rising edge), snapshots all player inputs and grants one action per active player, round-robin, over a valid/ready handshake. The starting player rotates every frame.
- Sits between the debounce/communication front end and game_logic in top_level.

Parameters:
- MAX_PLAYERS, 4, number of player slots; sets request vector widths. Player ID width is fixed at 2.

Ports:
- clock  in  1  system clock, 25 MHz pixel clock domain
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  frame tick from xvga, same clock domain, active high
- pause  in  1  when high, frame ticks are ignored
- num_players  in  2  active players = num_players+1
- req_up, req_down, req_left, req_right, req_chop  in  MAX_PLAYERS each  per-player level requests; bit i = player i
- req_carry  in  MAX_PLAYERS  per-player carry switch level
- act_ready  in  1  game_logic accepts the action
- act_valid  out  1  action offered
- act_player  out  2  player ID of the offered action
- act_code  out  3  action code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 chop, 6 pick, 7 drop
- carry_state  out  MAX_PLAYERS  granted carry status per player
- frame_done  out  1  one-cycle pulse at the end of the frame's arbitration
- frame_overrun  out  1  one-cycle pulse on a tick that arrives while not IDLE

Behaviour:
- Reset (async, reset_n=0):
  - act_valid=0, act_player=0, act_code=0, carry_state=0, frame_done=0, frame_overrun=0.
  - rr_ptr=0, state=IDLE, vsync_q=0.
  - Takes effect immediately mid-handshake; the pending action is lost.
- Edge detect: tick = vsync & ~vsync_q. vsync_q is registered every cycle.
- States: IDLE, SCAN, ISSUE, DONE.
- IDLE, on tick with pause=0:
  - Snapshot all req_* and num_players into registers.
  - n = num_players+1.
  - start = (rr_ptr < n) ? rr_ptr : 0. cur = start, visited = 0.
  - Go to SCAN.
  - tick with pause=1: ignored, stay IDLE, no outputs.
- SCAN, one cycle per player, computes the action for player cur from the snapshot. Priority:
  - 1. carry snapshot != carry_state[cur] → 6 (pick) if snapshot=1, else 7 (drop).
  - 2. chop → 5.
  - 3. up → 1.
  - 4. down → 2.
  - 5. left → 3.
  - 6. right → 4.
  - 7. else 0.
  - Code != 0: register act_player=cur and act_code, set act_valid=1, go to ISSUE.
  - Code == 0: advance (see below). No act_valid.
- ISSUE:
  - Hold act_valid, act_player and act_code stable until act_ready=1.
  - On the cycle act_valid & act_ready: act_valid<=0. Code 6 sets carry_state[cur]<=1; code 7 clears it. Then advance.
  - No timeout: ISSUE waits indefinitely.
- Advance:
  - visited+1 == n → DONE.
  - Else cur <= (cur+1) mod n, visited++, go to SCAN.
- DONE: frame_done=1 for exactly one cycle; rr_ptr <= (start+1) mod n; go to IDLE.
- Latency:
  - First act_valid rises 2 cycles after the tick cycle (tick → SCAN → act_valid).
  - Each idle player costs 1 cycle.
  - Each granted action costs 1 SCAN cycle plus the handshake cycles.
  - Minimum frame length with no actions: n+2 cycles from tick to frame_done.
- Tick while not IDLE: not queued; frame_overrun pulses one cycle. The current frame continues.
- Changes to req_*, num_players or pause mid-frame: no effect until the next snapshot.
- pause going high mid-frame: the current frame completes.
- rr_ptr wrap: if num_players shrinks so that rr_ptr >= n, the frame starts at player 0.
- carry_state changes only on a granted pick or drop. An ungranted carry toggle is retried next frame.

Test Plan:
- Reset then a single tick, num_players=1, req_up=4'b0001, req_chop=4'b0010, act_ready=1:
  - act_valid rises 2 cycles after the tick.
  - Grants (player 0, code 1), then (player 1, code 5).
  - frame_done pulses; rr_ptr=1.
  - Next frame grants player 1 first.
- num_players=3, all requests 0, 4 ticks:
  - act_valid is never asserted.
  - frame_done 6 cycles after each tick.
  - rr_ptr sequence 1,2,3,0.
- req_carry[2]=1, req_left[2]=1, num_players=2, act_ready held low 10 cycles:
  - act_player=2, act_code=6 held stable 10 cycles.
  - On ready, carry_state=4'b0100.
  - Next frame gives code 3 for player 2.
  - Dropping the switch later gives code 7 and clears the bit.
- Second vsync edge during a stalled ISSUE:
  - frame_overrun pulses once; no extra frame.
  - After ready, exactly one frame_done.
- pause=1 at tick: no state change.
- num_players changed mid-frame: the current frame still uses the snapshot count.
- Assert reset_n=0 mid-ISSUE:
  - act_valid drops immediately.
  - carry_state=0.
  - After release, the next tick starts at player 0.

Source files
------------

// File: rtl/player_action_arbiter.sv
// Per-frame arbiter that shares the single game_logic action port among up to
// four players. Each vsync rising edge snapshots every player's requests, then
// one action per active player is offered round-robin over valid/ready. The
// starting player rotates by one every frame.
//
// state | meaning
// IDLE  | waiting for a frame tick; inputs are not sampled
// SCAN  | one cycle per player: derive the action for r_cur from the snapshot
// ISSUE | action offered on act_*; held until act_ready
// DONE  | pulse frame_done, rotate the round-robin pointer
module player_action_arbiter #(
    parameter int MAX_PLAYERS = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   vsync,
    input  logic                   pause,
    input  logic [1:0]             num_players,
    input  logic [MAX_PLAYERS-1:0] req_up,
    input  logic [MAX_PLAYERS-1:0] req_down,
    input  logic [MAX_PLAYERS-1:0] req_left,
    input  logic [MAX_PLAYERS-1:0] req_right,
    input  logic [MAX_PLAYERS-1:0] req_chop,
    input  logic [MAX_PLAYERS-1:0] req_carry,
    input  logic                   act_ready,
    output logic                   act_valid,
    output logic [1:0]             act_player,
    output logic [2:0]             act_code,
    output logic [MAX_PLAYERS-1:0] carry_state,
    output logic                   frame_done,
    output logic                   frame_overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_vsync_q;
    logic [1:0]             r_rr_ptr;
    logic [1:0]             r_start;
    logic [1:0]             r_cur;
    logic [1:0]             r_visited;
    logic [2:0]             r_n;
    logic [MAX_PLAYERS-1:0] r_up_s;
    logic [MAX_PLAYERS-1:0] r_down_s;
    logic [MAX_PLAYERS-1:0] r_left_s;
    logic [MAX_PLAYERS-1:0] r_right_s;
    logic [MAX_PLAYERS-1:0] r_chop_s;
    logic [MAX_PLAYERS-1:0] r_carry_s;

    logic       w_tick;
    logic [2:0] w_n_in;
    logic [1:0] w_start_in;
    logic       w_last;
    logic [1:0] w_cur_next;
    logic [1:0] w_start_next;
    logic [2:0] w_code;

    // Tick detect, modulo-n successors and the action for the player under scan.
    // A carry mismatch outranks movement so a toggled switch is never starved.
    always_comb begin
        w_tick       = vsync & ~r_vsync_q;
        w_n_in       = {1'b0, num_players} + 3'd1;
        w_start_in   = ({1'b0, r_rr_ptr} < w_n_in) ? r_rr_ptr : 2'd0;
        w_last       = (({1'b0, r_visited} + 3'd1) == r_n);
        w_cur_next   = (({1'b0, r_cur} + 3'd1) == r_n) ? 2'd0 : r_cur + 2'd1;
        w_start_next = (({1'b0, r_start} + 3'd1) == r_n) ? 2'd0 : r_start + 2'd1;
        w_code       = 3'd0;
        if (r_carry_s[r_cur] != carry_state[r_cur]) begin
            w_code = r_carry_s[r_cur] ? 3'd6 : 3'd7;
        end else if (r_chop_s[r_cur]) begin
            w_code = 3'd5;
        end else if (r_up_s[r_cur]) begin
            w_code = 3'd1;
        end else if (r_down_s[r_cur]) begin
            w_code = 3'd2;
        end else if (r_left_s[r_cur]) begin
            w_code = 3'd3;
        end else if (r_right_s[r_cur]) begin
            w_code = 3'd4;
        end
    end

    // Frame FSM with registered handshake, carry and status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_vsync_q     <= 1'b0;
            r_rr_ptr      <= 2'd0;
            r_start       <= 2'd0;
            r_cur         <= 2'd0;
            r_visited     <= 2'd0;
            r_n           <= 3'd1;
            r_up_s        <= '0;
            r_down_s      <= '0;
            r_left_s      <= '0;
            r_right_s     <= '0;
            r_chop_s      <= '0;
            r_carry_s     <= '0;
            act_valid     <= 1'b0;
            act_player    <= 2'd0;
            act_code      <= 3'd0;
            carry_state   <= '0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            r_vsync_q     <= vsync;
            frame_done    <= 1'b0;
            frame_overrun <= w_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_tick && !pause) begin
                        r_up_s    <= req_up;
                        r_down_s  <= req_down;
                        r_left_s  <= req_left;
                        r_right_s <= req_right;
                        r_chop_s  <= req_chop;
                        r_carry_s <= req_carry;
                        r_n       <= w_n_in;
                        r_start   <= w_start_in;
                        r_cur     <= w_start_in;
                        r_visited <= 2'd0;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_code != 3'd0) begin
                        act_valid  <= 1'b1;
                        act_player <= r_cur;
                        act_code   <= w_code;
                        r_state    <= S_ISSUE;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cur     <= w_cur_next;
                        r_visited <= r_visited + 2'd1;
                    end
                end
                S_ISSUE: begin
                    if (act_ready) begin
                        act_valid <= 1'b0;
                        if (act_code == 3'd6) begin
                            carry_state[r_cur] <= 1'b1;
                        end else if (act_code == 3'd7) begin
                            carry_state[r_cur] <= 1'b0;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cur     <= w_cur_next;
                            r_visited <= r_visited + 2'd1;
                            r_state   <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    r_rr_ptr   <= w_start_next;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
